// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        SYS_RST,
        RUN,
        FAIL
    } state_t;

    localparam int RELOCK_W = 8;

    // One shared timer covers every phase, so it is sized for the longest one plus a spare bit.
    function automatic int timer_width(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its environment.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level-type.
interface pll_lock_supervisor_if;
    import pll_sup_pkg::*;

    logic                pll_locked;
    logic                soft_reset_req;
    logic                pll_rst;
    logic                sys_reset;
    logic                ready;
    logic                fault;
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        output pll_locked, soft_reset_req,
        input  pll_rst, sys_reset, ready, fault, relock_count
    );

    modport slave (
        input  pll_locked, soft_reset_req,
        output pll_rst, sys_reset, ready, fault, relock_count
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk cycles.
// Backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock, retries on timeout and gates the system reset.
// Latency: lock changes act 3 cycles after the pin moves; soft reset acts on the next edge.
// Backpressure: none; all outputs are registered levels.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int SYS_RST_HOLD_CYC = 64,
    parameter int MAX_RETRIES      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pll_lock_supervisor_if.slave sup
);

    localparam int TW = timer_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                                    LOCK_STABLE_CYC, SYS_RST_HOLD_CYC);

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       timer;
    logic [7:0]          retries;
    logic [7:0]          retries_nxt;
    logic [RELOCK_W-1:0] relock;
    logic                relock_inc;
    logic                lk;
    logic                soft_q;
    logic                sr;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (sup.pll_locked),
        .q   (lk)
    );

    assign sr               = sup.soft_reset_req & ~soft_q;
    assign sup.relock_count = relock;

    always_ff @(posedge clk) begin
        if (rst) state <= PLL_RST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        retries_nxt = retries;
        relock_inc  = 1'b0;
        case (state)
            PLL_RST: begin
                if (timer == TW'(RST_PULSE_CYC - 1)) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABLE;
                end else if (timer == TW'(LOCK_TIMEOUT_CYC - 1)) begin
                    retries_nxt = retries + 8'd1;
                    state_nxt   = (retries_nxt == 8'(MAX_RETRIES)) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                end else if (timer == TW'(LOCK_STABLE_CYC - 1)) begin
                    state_nxt   = SYS_RST;
                    retries_nxt = 8'd0;
                end
            end
            SYS_RST: begin
                // Losing lock outranks an expiring hold.
                if (!lk)                                   state_nxt = PLL_RST;
                else if (timer == TW'(SYS_RST_HOLD_CYC - 1)) state_nxt = RUN;
            end
            RUN: begin
                if (!lk) begin
                    state_nxt  = PLL_RST;
                    relock_inc = 1'b1;
                end else if (sr) begin
                    state_nxt = SYS_RST;
                end
            end
            FAIL: begin
                if (sr) begin
                    state_nxt   = PLL_RST;
                    retries_nxt = 8'd0;
                end
            end
            default: state_nxt = PLL_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            retries <= '0;
            relock  <= '0;
            soft_q  <= 1'b0;
        end else begin
            retries <= retries_nxt;
            soft_q  <= sup.soft_reset_req;
            // FAIL parks the timer; any state change restarts it.
            if (state_nxt != state)  timer <= '0;
            else if (state != FAIL)  timer <= timer + TW'(1);
            if (relock_inc && (relock != '1)) relock <= relock + RELOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sup.pll_rst   <= 1'b1;
            sup.sys_reset <= 1'b1;
            sup.ready     <= 1'b0;
            sup.fault     <= 1'b0;
        end else begin
            sup.pll_rst   <= (state_nxt == PLL_RST);
            sup.sys_reset <= (state_nxt != RUN);
            sup.ready     <= (state_nxt == RUN);
            sup.fault     <= (state_nxt == FAIL);
        end
    end

endmodule
